// File: rtl/bev_dispenser_n_if.sv
// bev_dispenser_n_if
//   Groups the coin/keypad front-end signals and the dispenser status/actuator
//   signals of the multi-channel beverage dispenser into one bundle.
//   Handshake: coin_valid qualifies coin_value for exactly one cycle; sel, cancel
//   and restock are one-cycle request pulses; change_valid qualifies change for
//   one cycle; coin_reject / err_funds / err_stock are one-cycle strobes. There
//   is no back-pressure: requests not acted upon are dropped (or rejected).
//   Ports (modport view of the dispenser, "slave"):
//     in : coin_valid, coin_value, sel, cancel, restock
//     out: dispense, change, change_valid, credit, coin_reject, err_funds,
//          err_stock, stock_empty, busy, state_dbg (current FSM state)
interface bev_if #(
   parameter int NUM_BEV = 4,
   parameter int MONEY_W = 10
);
   logic               coin_valid;
   logic [MONEY_W-1:0] coin_value;
   logic [NUM_BEV-1:0] sel;
   logic               cancel;
   logic               restock;
   logic [NUM_BEV-1:0] dispense;
   logic [MONEY_W-1:0] change;
   logic               change_valid;
   logic [MONEY_W-1:0] credit;
   logic               coin_reject;
   logic               err_funds;
   logic               err_stock;
   logic [NUM_BEV-1:0] stock_empty;
   logic               busy;
   logic [1:0]         state_dbg;

   modport master (
      output coin_valid, coin_value, sel, cancel, restock,
      input  dispense, change, change_valid, credit, coin_reject,
             err_funds, err_stock, stock_empty, busy, state_dbg
   );

   modport slave (
      input  coin_valid, coin_value, sel, cancel, restock,
      output dispense, change, change_valid, credit, coin_reject,
             err_funds, err_stock, stock_empty, busy, state_dbg
   );
endinterface

// File: rtl/bev_dispenser_n.sv
// bev_dispenser_n
//   Multi-channel beverage dispenser. Coins accumulate into a credit register
//   (capped at MAX_CREDIT); a one-hot request (lowest set bit wins) is checked
//   against per-channel stock and price, then the channel's dispense line is
//   held for DISPENSE_CYCLES cycles and any remaining credit is returned as
//   change in a single strobe.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : bev_if slave modport (coin/keypad inputs, actuator/status outputs)
module bev_dispenser_n #(
   parameter int                        NUM_BEV         = 4,
   parameter int                        MONEY_W         = 10,
   parameter int                        STOCK_W         = 4,
   parameter int                        INIT_STOCK      = 5,
   parameter logic [NUM_BEV*MONEY_W-1:0] PRICES         = {10'd250, 10'd200, 10'd150, 10'd125},
   parameter int                        MAX_CREDIT      = 1000,
   parameter int                        DISPENSE_CYCLES = 4
) (
   input logic clk,
   input logic rst,
   bev_if.slave bus
);

   localparam int TW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
   localparam int IW = (NUM_BEV > 1) ? $clog2(NUM_BEV) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPENSE = 2'd1,
      CHANGE   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [MONEY_W-1:0] credit_q, credit_d;
   logic [MONEY_W-1:0] change_q, change_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [NUM_BEV-1:0] dispense_q, dispense_d;
   logic               change_valid_q, change_valid_d;
   logic               coin_reject_q, coin_reject_d;
   logic               err_funds_q, err_funds_d;
   logic               err_stock_q, err_stock_d;
   logic [STOCK_W-1:0] stock_q [NUM_BEV];
   logic [STOCK_W-1:0] stock_d [NUM_BEV];

   logic [MONEY_W-1:0] price_tab [NUM_BEV];
   logic [IW-1:0]      sel_idx;
   logic [MONEY_W:0]   coin_sum;
   logic               coin_ok;
   logic               take_coin;
   logic [NUM_BEV-1:0] empty_c;

   for (genvar g = 0; g < NUM_BEV; g++) begin : g_price
      assign price_tab[g] = PRICES[g*MONEY_W +: MONEY_W];
   end

   // Lowest set request bit wins; higher bits in the same pulse are dropped.
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_BEV - 1; i >= 0; i--) begin
         if (bus.sel[i]) sel_idx = IW'(i);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_BEV; i++) begin
         empty_c[i] = (stock_q[i] == '0);
      end
   end

   // Sum carried one bit wider so a large coin cannot wrap past the ceiling.
   assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
   assign coin_ok  = (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      change_d       = change_q;
      timer_d        = timer_q;
      dispense_d     = dispense_q;
      change_valid_d = 1'b0;
      coin_reject_d  = 1'b0;
      err_funds_d    = 1'b0;
      err_stock_d    = 1'b0;
      stock_d        = stock_q;
      take_coin      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.cancel) begin
               if (credit_q != '0) state_d = CHANGE;
               coin_reject_d = bus.coin_valid;
            end else if (bus.sel != '0) begin
               // Stock failure masks a funds failure.
               if (empty_c[sel_idx]) begin
                  err_stock_d = 1'b1;
                  take_coin   = bus.coin_valid;
               end else if (credit_q < price_tab[sel_idx]) begin
                  err_funds_d = 1'b1;
                  take_coin   = bus.coin_valid;
               end else begin
                  credit_d         = credit_q - price_tab[sel_idx];
                  stock_d[sel_idx] = stock_q[sel_idx] - STOCK_W'(1);
                  dispense_d       = NUM_BEV'(1) << sel_idx;
                  timer_d          = TW'(DISPENSE_CYCLES - 1);
                  state_d          = DISPENSE;
                  coin_reject_d    = bus.coin_valid;
               end
            end else begin
               if (bus.restock) begin
                  for (int i = 0; i < NUM_BEV; i++) stock_d[i] = STOCK_W'(INIT_STOCK);
               end
               take_coin = bus.coin_valid;
            end
         end

         DISPENSE: begin
            coin_reject_d = bus.coin_valid;
            if (timer_q == '0) begin
               dispense_d = '0;
               state_d    = (credit_q != '0) ? CHANGE : IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         CHANGE: begin
            coin_reject_d  = bus.coin_valid;
            change_d       = credit_q;
            change_valid_d = 1'b1;
            credit_d       = '0;
            state_d        = IDLE;
         end

         default: state_d = IDLE;
      endcase

      if (take_coin) begin
         if (coin_ok) credit_d = coin_sum[MONEY_W-1:0];
         else         coin_reject_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         change_q       <= '0;
         timer_q        <= '0;
         dispense_q     <= '0;
         change_valid_q <= 1'b0;
         coin_reject_q  <= 1'b0;
         err_funds_q    <= 1'b0;
         err_stock_q    <= 1'b0;
         for (int i = 0; i < NUM_BEV; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         change_q       <= change_d;
         timer_q        <= timer_d;
         dispense_q     <= dispense_d;
         change_valid_q <= change_valid_d;
         coin_reject_q  <= coin_reject_d;
         err_funds_q    <= err_funds_d;
         err_stock_q    <= err_stock_d;
         for (int i = 0; i < NUM_BEV; i++) stock_q[i] <= stock_d[i];
      end
   end

   assign bus.dispense     = dispense_q;
   assign bus.change       = change_q;
   assign bus.change_valid = change_valid_q;
   assign bus.credit       = credit_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.err_funds    = err_funds_q;
   assign bus.err_stock    = err_stock_q;
   assign bus.stock_empty  = empty_c;
   assign bus.busy         = (state_q == DISPENSE) || (state_q == CHANGE);
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_bev_dispenser_n.sv
module tb_bev_dispenser_n;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   bev_if #(.NUM_BEV(4), .MONEY_W(10)) bus ();

   bev_dispenser_n dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   // Advance one rising edge and settle 1 time unit past it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
      bus.sel        = '0;
      bus.cancel     = 1'b0;
      bus.restock    = 1'b0;
   endtask

   task automatic drive_coin(input logic [9:0] v);
      bus.coin_valid = 1'b1;
      bus.coin_value = v;
      cycle();
      idle_inputs();
   endtask

   task automatic drive_sel(input logic [3:0] s);
      bus.sel = s;
      cycle();
      idle_inputs();
   endtask

   task automatic drive_cancel();
      bus.cancel = 1'b1;
      cycle();
      idle_inputs();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      cycle();
      cycle();
      if (bus.credit !== 10'd0) $display("FAIL reset_credit got=%0d exp=0", bus.credit);
      else pass_cnt++;
      total_cnt++;
      if (bus.dispense !== 4'b0 || bus.busy !== 1'b0 || bus.change_valid !== 1'b0 ||
          bus.change !== 10'd0)
         $display("FAIL reset_outputs got disp=%b busy=%b cv=%b chg=%0d exp all 0",
                  bus.dispense, bus.busy, bus.change_valid, bus.change);
      else pass_cnt++;
      total_cnt++;
      if (bus.stock_empty !== 4'b0 || dut.stock_q[2] !== 4'd5)
         $display("FAIL reset_stock got empty=%b stock2=%0d exp 0000/5",
                  bus.stock_empty, dut.stock_q[2]);
      else pass_cnt++;
      total_cnt++;
      rst = 1'b1;
      cycle();
   endtask

   task automatic test_exact_buy();
      drive_coin(10'd100);
      if (bus.credit !== 10'd100) $display("FAIL t1_credit1 got=%0d exp=100", bus.credit);
      else pass_cnt++;
      total_cnt++;
      drive_coin(10'd25);
      drive_coin(10'd25);
      if (bus.credit !== 10'd150 || bus.coin_reject !== 1'b0)
         $display("FAIL t1_credit3 got=%0d rej=%b exp=150/0", bus.credit, bus.coin_reject);
      else pass_cnt++;
      total_cnt++;
      drive_sel(4'b0010);
      if (bus.dispense !== 4'b0010 || bus.credit !== 10'd0 || bus.busy !== 1'b1)
         $display("FAIL t1_accept got disp=%b credit=%0d busy=%b exp 0010/0/1",
                  bus.dispense, bus.credit, bus.busy);
      else pass_cnt++;
      total_cnt++;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (bus.dispense !== 4'b0010) $display("FAIL t1_hold%0d got=%b exp=0010", k, bus.dispense);
         else pass_cnt++;
         total_cnt++;
      end
      cycle();
      if (bus.dispense !== 4'b0 || bus.busy !== 1'b0 || bus.change_valid !== 1'b0)
         $display("FAIL t1_end got disp=%b busy=%b cv=%b exp 0000/0/0",
                  bus.dispense, bus.busy, bus.change_valid);
      else pass_cnt++;
      total_cnt++;
      cycle();
      if (bus.change_valid !== 1'b0 || dut.stock_q[1] !== 4'd4)
         $display("FAIL t1_nochange got cv=%b stock1=%0d exp 0/4", bus.change_valid, dut.stock_q[1]);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_change();
      drive_coin(10'd500);
      drive_sel(4'b0001);
      if (bus.dispense !== 4'b0001 || bus.credit !== 10'd375)
         $display("FAIL t2_accept got disp=%b credit=%0d exp 0001/375", bus.dispense, bus.credit);
      else pass_cnt++;
      total_cnt++;
      cycle(); cycle(); cycle();
      if (bus.dispense !== 4'b0001) $display("FAIL t2_hold got=%b exp=0001", bus.dispense);
      else pass_cnt++;
      total_cnt++;
      cycle();
      if (bus.dispense !== 4'b0 || bus.busy !== 1'b1 || bus.change_valid !== 1'b0)
         $display("FAIL t2_changestate got disp=%b busy=%b cv=%b exp 0000/1/0",
                  bus.dispense, bus.busy, bus.change_valid);
      else pass_cnt++;
      total_cnt++;
      cycle();
      if (bus.change_valid !== 1'b1 || bus.change !== 10'd375 || bus.credit !== 10'd0)
         $display("FAIL t2_change got cv=%b chg=%0d credit=%0d exp 1/375/0",
                  bus.change_valid, bus.change, bus.credit);
      else pass_cnt++;
      total_cnt++;
      cycle();
      if (bus.change_valid !== 1'b0 || bus.change !== 10'd375 || bus.busy !== 1'b0)
         $display("FAIL t2_after got cv=%b chg=%0d busy=%b exp 0/375/0",
                  bus.change_valid, bus.change, bus.busy);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_funds_cancel();
      drive_cancel();
      cycle();
      if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL t3_cancel0 got cv=%b busy=%b exp 0/0", bus.change_valid, bus.busy);
      else pass_cnt++;
      total_cnt++;
      drive_coin(10'd100);
      drive_sel(4'b1000);
      if (bus.err_funds !== 1'b1 || bus.err_stock !== 1'b0 || bus.credit !== 10'd100 ||
          bus.dispense !== 4'b0)
         $display("FAIL t3_funds got ef=%b es=%b credit=%0d disp=%b exp 1/0/100/0000",
                  bus.err_funds, bus.err_stock, bus.credit, bus.dispense);
      else pass_cnt++;
      total_cnt++;
      cycle();
      if (bus.err_funds !== 1'b0) $display("FAIL t3_pulse got=%b exp=0", bus.err_funds);
      else pass_cnt++;
      total_cnt++;
      drive_cancel();
      cycle();
      if (bus.change_valid !== 1'b1 || bus.change !== 10'd100 || bus.credit !== 10'd0)
         $display("FAIL t3_refund got cv=%b chg=%0d credit=%0d exp 1/100/0",
                  bus.change_valid, bus.change, bus.credit);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_stock();
      for (int n = 0; n < 5; n++) begin
         drive_coin(10'd200);
         drive_sel(4'b0100);
         if (bus.dispense !== 4'b0100) $display("FAIL t4_buy%0d got=%b exp=0100", n, bus.dispense);
         else pass_cnt++;
         total_cnt++;
         cycle(); cycle(); cycle(); cycle();
      end
      if (bus.stock_empty !== 4'b0100) $display("FAIL t4_empty got=%b exp=0100", bus.stock_empty);
      else pass_cnt++;
      total_cnt++;
      drive_coin(10'd200);
      drive_sel(4'b0100);
      if (bus.err_stock !== 1'b1 || bus.dispense !== 4'b0 || bus.credit !== 10'd200)
         $display("FAIL t4_nostock got es=%b disp=%b credit=%0d exp 1/0000/200",
                  bus.err_stock, bus.dispense, bus.credit);
      else pass_cnt++;
      total_cnt++;
      drive_cancel();
      cycle();
      // empty channel with zero credit: only the stock error fires
      drive_sel(4'b0100);
      if (bus.err_stock !== 1'b1 || bus.err_funds !== 1'b0)
         $display("FAIL t4_bothfail got es=%b ef=%b exp 1/0", bus.err_stock, bus.err_funds);
      else pass_cnt++;
      total_cnt++;
      bus.restock = 1'b1;
      cycle();
      idle_inputs();
      if (bus.stock_empty !== 4'b0 || dut.stock_q[2] !== 4'd5)
         $display("FAIL t4_restock got empty=%b stock2=%0d exp 0000/5", bus.stock_empty, dut.stock_q[2]);
      else pass_cnt++;
      total_cnt++;
   endtask

   task automatic test_coin_reject();
      drive_coin(10'd500);
      drive_coin(10'd400);
      drive_coin(10'd200);
      if (bus.coin_reject !== 1'b1 || bus.credit !== 10'd900)
         $display("FAIL t5_ceiling got rej=%b credit=%0d exp 1/900", bus.coin_reject, bus.credit);
      else pass_cnt++;
      total_cnt++;
      bus.sel        = 4'b0110;
      bus.coin_valid = 1'b1;
      bus.coin_value = 10'd50;
      cycle();
      idle_inputs();
      if (bus.dispense !== 4'b0010 || bus.coin_reject !== 1'b1 || bus.credit !== 10'd750)
         $display("FAIL t5_lowbit got disp=%b rej=%b credit=%0d exp 0010/1/750",
                  bus.dispense, bus.coin_reject, bus.credit);
      else pass_cnt++;
      total_cnt++;
      drive_coin(10'd10);
      if (bus.coin_reject !== 1'b1 || bus.credit !== 10'd750 || bus.dispense !== 4'b0010)
         $display("FAIL t5_busycoin got rej=%b credit=%0d disp=%b exp 1/750/0010",
                  bus.coin_reject, bus.credit, bus.dispense);
      else pass_cnt++;
      total_cnt++;
      cycle(); cycle(); cycle(); cycle();
      if (bus.change_valid !== 1'b1 || bus.change !== 10'd750)
         $display("FAIL t5_change got cv=%b chg=%0d exp 1/750", bus.change_valid, bus.change);
      else pass_cnt++;
      total_cnt++;
      drive_coin(10'd500);
      drive_coin(10'd500);
      if (bus.coin_reject !== 1'b0 || bus.credit !== 10'd1000)
         $display("FAIL t5_exactmax got rej=%b credit=%0d exp 0/1000", bus.coin_reject, bus.credit);
      else pass_cnt++;
      total_cnt++;
      drive_coin(10'd1023);
      if (bus.coin_reject !== 1'b1 || bus.credit !== 10'd1000)
         $display("FAIL t5_wrap got rej=%b credit=%0d exp 1/1000", bus.coin_reject, bus.credit);
      else pass_cnt++;
      total_cnt++;
      drive_cancel();
      cycle();
   endtask

   task automatic test_reset_mid_dispense();
      drive_coin(10'd500);
      drive_sel(4'b0001);
      cycle();
      #2;
      rst = 1'b0;
      #1;
      if (bus.dispense !== 4'b0 || bus.credit !== 10'd0 || bus.busy !== 1'b0)
         $display("FAIL t6_abort got disp=%b credit=%0d busy=%b exp 0000/0/0",
                  bus.dispense, bus.credit, bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (dut.stock_q[0] !== 4'd5) $display("FAIL t6_stock got=%0d exp=5", dut.stock_q[0]);
      else pass_cnt++;
      total_cnt++;
      cycle();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (bus.change_valid !== 1'b0) $display("FAIL t6_nochange%0d got=%b exp=0", k, bus.change_valid);
         else pass_cnt++;
         total_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst       = 1'b0;
      idle_inputs();
      test_reset();
      test_exact_buy();
      test_change();
      test_funds_cancel();
      test_stock();
      test_coin_reject();
      test_reset_mid_dispense();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bev_dispenser_n.md
Name: bev_dispenser_n

Overview:
- Parametrised, multi-channel successor to the three-beverage dispenser.
- Accepts coin deposits into a credit register and arbitrates one-hot beverage requests against per-channel prices and stock counters.
- Drives a timed dispense pulse, then returns change.
- Sits between the coin/keypad front end and the dispense actuators.

Parameters:
NUM_BEV, 4, number of beverage channels (1..8)
MONEY_W, 10, width of coin, credit, price and change values
STOCK_W, 4, width of each per-channel stock counter
INIT_STOCK, 5, stock value loaded on reset and on restock
PRICES, {10'd250,10'd200,10'd150,10'd125}, packed NUM_BEV*MONEY_W price table; channel i uses bits [i*MONEY_W +: MONEY_W]
MAX_CREDIT, 1000, credit ceiling; must be < 2**MONEY_W
DISPENSE_CYCLES, 4, cycles the dispense output is held high (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
coin_valid  in  1  one-cycle coin strobe
coin_value  in  MONEY_W  coin value, qualified by coin_valid
sel  in  NUM_BEV  beverage request, one-cycle pulse per bit
cancel  in  1  request refund of current credit
restock  in  1  reload all stock counters to INIT_STOCK
dispense  out  NUM_BEV  one-hot dispense drive
change  out  MONEY_W  refund amount, qualified by change_valid
change_valid  out  1  one-cycle change strobe
credit  out  MONEY_W  current credit register
coin_reject  out  1  one-cycle pulse: offered coin not accepted
err_funds  out  1  one-cycle pulse: request with credit < price
err_stock  out  1  one-cycle pulse: request on empty channel
stock_empty  out  NUM_BEV  per-channel stock == 0 (combinational from counters)
busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; credit=0; all stock=INIT_STOCK.
  - dispense, change, change_valid, coin_reject, err_funds and err_stock all 0.
  - Dispense timer = 0.
- FSM states: IDLE, DISPENSE, CHANGE.
- IDLE priority each cycle: cancel > sel > restock > coin.
  - cancel:
    - credit>0 -> CHANGE.
    - credit==0 -> no action.
    - A coin offered in the same cycle is rejected.
  - sel != 0:
    - Lowest set index i wins; other bits are ignored.
    - Evaluation uses the registered credit, not including a same-cycle coin.
    - stock[i]==0 -> err_stock pulse next cycle, stay IDLE.
    - Else if credit < price[i] -> err_funds pulse next cycle, stay IDLE.
    - If both fail, only err_stock pulses.
    - Accept: next cycle credit -= price[i], stock[i] -= 1, dispense[i]=1, timer=DISPENSE_CYCLES-1, state DISPENSE. A same-cycle coin is rejected.
    - Reject: a same-cycle coin is processed normally.
  - restock: all counters = INIT_STOCK next cycle. A same-cycle coin is processed normally.
  - coin_valid:
    - credit + coin_value <= MAX_CREDIT -> credit updates next cycle.
    - Otherwise credit is unchanged and coin_reject pulses next cycle.
    - Compute the sum at MONEY_W+1 bits to avoid wrap.
- DISPENSE:
  - dispense[i] held high for exactly DISPENSE_CYCLES cycles total.
  - Timer decrements; at 0, dispense clears and state goes to CHANGE, or IDLE if credit==0.
  - coin_valid -> coin_reject. sel, cancel and restock are ignored.
- CHANGE (one cycle):
  - change=credit, change_valid=1, credit=0, then IDLE.
  - change holds its value until the next change_valid; it resets to 0.
  - coin_valid -> coin_reject.
- Latency:
  - Request to dispense high: 1 cycle.
  - Request to change_valid: DISPENSE_CYCLES+1 cycles.
- Stock counters never underflow; empty channels cannot be accepted.
- Reset asserted mid-DISPENSE or mid-CHANGE aborts immediately to reset values. Credit is lost; no change is issued.
- All error and reject strobes are registered single-cycle pulses.

Test Plan:
1. Coins 100, 25, 25 in IDLE -> credit 150; sel=4'b0010 -> dispense[1] high for 4 cycles, credit 0, no change_valid; stock[1]=4.
2. Coin 500, sel=4'b0001 -> dispense[0] for 4 cycles, then change_valid with change=375, credit 0.
3. Credit 100, sel=4'b1000 -> err_funds pulse, credit stays 100; then cancel -> change_valid, change=100, credit 0.
4. Six accepted buys on channel 2 with sufficient credit each -> first five dispense; sixth gives err_stock and stock_empty[2]=1. restock -> stock_empty[2]=0.
5. Credit 900, coin 200 -> coin_reject, credit 900. sel=4'b0110 with coin_valid in the same cycle -> channel 1 dispensed, coin rejected, change=750.
6. Deposit 500, sel=4'b0001, drop rst during the 2nd dispense cycle -> all outputs 0 immediately, credit 0, stock[0]=INIT_STOCK.
